// File: rtl/host_uart_rx_pkg.sv
// Shared definitions for the host UART blocks: data width and FSM state encodings.
// The PARITY state exists only when HOST_UART_PARITY_EN is defined.
package host_uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef HOST_UART_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

endpackage

// File: rtl/host_uart_fifo.sv
// First-word-fall-through receive FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module host_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_rd;
  logic             do_wr;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head byte is presented directly; forced to zero while empty so reset shows dout=0.
  assign dout = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  // Storage array, written without reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Pointer update; the extra top bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/host_uart_rx.sv
// Host UART receiver: synchronizer, frame-decoding FSM, receive FIFO, sticky error flags.
// Optional even-parity bit enabled by defining HOST_UART_PARITY_EN (default build is 8N1).
module host_uart_rx
  import host_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic rx_sync1_reg, rx_s, rx_prev_reg;

  uart_state_t                state_reg, state_next;
  logic [CW-1:0]              cnt_reg, cnt_next;
  logic [2:0]                 bit_cnt_reg, bit_cnt_next;
  logic [UART_DATA_BITS-1:0]  shift_reg, shift_next;
  logic                       push_reg, push_next;
  logic                       ferr_set;
  logic                       ovr_set;
  logic                       frame_err_reg, overrun_reg;
`ifdef HOST_UART_PARITY_EN
  logic                       par_err_reg, par_err_next;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_reg <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev_reg  <= 1'b1;
    end else begin
      rx_sync1_reg <= rx;
      rx_s         <= rx_sync1_reg;
      rx_prev_reg  <= rx_s;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      push_reg    <= 1'b0;
`ifdef HOST_UART_PARITY_EN
      par_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      push_reg    <= push_next;
`ifdef HOST_UART_PARITY_EN
      par_err_reg <= par_err_next;
`endif
    end
  end

  // Next-state logic: start is checked at half a bit, every later sample one bit apart.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    push_next    = 1'b0;
    ferr_set     = 1'b0;
`ifdef HOST_UART_PARITY_EN
    par_err_next = par_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s) begin
          state_next   = ST_START;
          bit_cnt_next = '0;
        end
      end
      ST_START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_DATA;
`ifdef HOST_UART_PARITY_EN
          par_err_next = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
`ifdef HOST_UART_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef HOST_UART_PARITY_EN
      ST_PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          par_err_next = (rx_s != ^shift_reg);
          state_next   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            ferr_set   = 1'b1;
            state_next = ST_WAIT_IDLE;
`ifdef HOST_UART_PARITY_EN
          end else if (par_err_reg) begin
            ferr_set   = 1'b1;
            state_next = ST_IDLE;
`endif
          end else begin
            push_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // A push is lost only if the FIFO is full and no pop frees a slot this cycle.
  assign ovr_set = push_reg && full && !rd_en;

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err_reg <= 1'b1;
      else if (err_clr) frame_err_reg <= 1'b0;
      if (ovr_set)      overrun_reg   <= 1'b1;
      else if (err_clr) overrun_reg   <= 1'b0;
    end
  end

  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

  host_uart_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push_reg),
    .din   (shift_reg),
    .rd_en (rd_en),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_host_uart_rx.sv
// Directed testbench for host_uart_rx; inputs driven and outputs sampled on the falling edge.
module tb_host_uart_rx;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;
`ifdef HOST_UART_PARITY_EN
  localparam int LAT_LIMIT = 11 * CPB + 4;
`else
  localparam int LAT_LIMIT = 10 * CPB + 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  host_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Serial frame; abort_bit < 8 pulses reset mid-bit and releases the line.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input int abort_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        idle(CPB / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rx  = 1'b1;
        $display("tx %02h aborted by reset at bit %0d", d, i);
        return;
      end
      idle(CPB);
    end
`ifdef HOST_UART_PARITY_EN
    rx = par_bit;
    idle(CPB);
`endif
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(4);
    $display("tx %02h stop=%0b par=%0b", d, stop_bit, par_bit);
  endtask

  task automatic pop();
    $display("rd %02h", dout);
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    idle(4);

    // Single byte latency and value
    lat = -1;
    fork
      send_frame(8'h41, 1'b1, even_par(8'h41), 99);
      begin
        for (int i = 1; i <= LAT_LIMIT; i++) begin
          @(negedge clk);
          if (!empty) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("lat_0x41", (lat > 0) ? 32'd1 : 32'd0, 1);
    check("dout_0x41", dout, 8'h41);
    check("ferr_0x41", frame_err, 0);
    pop();
    check("empty_after_pop", empty, 1);

    // Fill beyond capacity, then drain (pointers wrap through the FIFO end)
    for (int b = 0; b < 17; b++) begin
      send_frame(8'(b), 1'b1, even_par(8'(b)), 99);
      if (b == 14) check("full_at_15", full, 0);
      if (b == 15) begin
        check("full_at_16", full, 1);
        check("ovr_at_16", overrun, 0);
      end
    end
    check("ovr_at_17", overrun, 1);
    check("full_at_17", full, 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), dout, 32'(i));
      pop();
    end
    check("empty_drained", empty, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Bad stop bit, clear, then a good frame
    send_frame(8'h55, 1'b0, even_par(8'h55), 99);
    check("ferr_bad_stop", frame_err, 1);
    check("empty_bad_stop", empty, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("ferr_cleared", frame_err, 0);
    send_frame(8'hAA, 1'b1, even_par(8'hAA), 99);
    check("dout_0xAA", dout, 8'hAA);
    check("ferr_0xAA", frame_err, 0);
    pop();

    // Short glitch on the idle line
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    $display("glitch 2 cycles");
    check("glitch_empty", empty, 1);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);
    send_frame(8'h5A, 1'b1, even_par(8'h5A), 99);
    check("dout_after_glitch", dout, 8'h5A);

    // Reset mid-frame discards the partial byte and the queued 0x5A
    send_frame(8'hC3, 1'b1, even_par(8'hC3), 4);
    idle(20);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_ferr", frame_err, 0);
    send_frame(8'h3C, 1'b1, even_par(8'h3C), 99);
    check("dout_0x3C", dout, 8'h3C);
    pop();
    check("only_0x3C", empty, 1);

`ifdef HOST_UART_PARITY_EN
    // Parity mismatch then correct parity
    send_frame(8'h07, 1'b1, 1'b0, 99);
    check("par_bad_ferr", frame_err, 1);
    check("par_bad_empty", empty, 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 99);
    check("par_ok_dout", dout, 8'h07);
    check("par_ok_ferr", frame_err, 0);
    pop();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/host_uart_rx.md
HOST_UART_RX -- requirements
Module: host_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clk cycles per UART bit; legal values are even and >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries; legal values are powers of two >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx  input  1  serial line from the CPU top's Tx; idles high; asynchronous to clk.
REQ-006 SHALL have port rd_en  input  1  pop the FIFO head.
REQ-007 SHALL have port dout  output  8  FIFO head byte, first-word-fall-through.
REQ-008 SHALL have port empty  output  1  FIFO holds no bytes.
REQ-009 SHALL have port full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port frame_err  output  1  sticky flag: bad stop bit (or bad parity) seen.
REQ-011 SHALL have port overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-012 SHALL have port err_clr  input  1  clears both sticky flags.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer, initialised high; all decoding uses the synchronized value.
REQ-014 SHALL use the FSM IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus a WAIT_IDLE state.
REQ-015 IDLE: a high-to-low transition of synchronized rx SHALL move the FSM to START and zero the bit counter.
REQ-016 START: after CLKS_PER_BIT/2 cycles, low SHALL go to DATA; high SHALL be treated as a glitch and return to IDLE with no flag set.
REQ-017 DATA: SHALL sample 8 bits, LSB first, each exactly CLKS_PER_BIT cycles after the previous sample.
REQ-018 STOP: the sample SHALL be taken CLKS_PER_BIT cycles after the last data (or parity) sample.
REQ-019 STOP sample high with no error SHALL push the byte, in the cycle after the sample, when full is low; when full is high, SHALL drop the byte and set overrun.
REQ-020 STOP sample low SHALL discard the byte, set frame_err, and enter WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL stay until synchronized rx is high, then go to IDLE.
REQ-022 rd_en with empty low SHALL advance the read pointer; rd_en with empty high SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL both take effect, including when full: full is evaluated after the pop, so no overrun.
REQ-024 Read and write pointers SHALL carry one extra wrap bit; full/empty SHALL derive from pointer compare; wrap at FIFO_DEPTH SHALL be seamless.
REQ-025 dout SHALL equal the head entry whenever empty is low; its value is don't-care when empty.
REQ-026 Flag set and err_clr in the same cycle: set SHALL win.
REQ-027 empty SHALL fall in the cycle after the push.

Reset
REQ-028 rst SHALL force: FSM to IDLE; synchronizer to 1; pointers, counters and both sticky flags to 0; empty=1; full=0; dout=0.
REQ-029 rst asserted mid-frame SHALL abandon the partial byte without setting a flag; FIFO contents SHALL be discarded.

Configuration
REQ-030 With HOST_UART_PARITY_EN defined, SHALL insert the PARITY state after DATA, sampled one bit time after bit 7, using even parity.
REQ-031 A parity mismatch SHALL set frame_err and drop the byte, even when the stop bit is good; the stop bit SHALL be waited for normally.
REQ-032 Without HOST_UART_PARITY_EN, frames SHALL be 8N1, no PARITY state or logic SHALL exist, and the stop sample SHALL be 9 bit times after the start mid-sample.

Structure
REQ-033 FSM state encodings and UART_DATA_BITS=8 SHALL live in the shared package/include header used by the UART blocks.
REQ-034 The FIFO SHALL be a sub-module host_uart_fifo, parameterised by width 8 and FIFO_DEPTH.

Verification
REQ-035 Send 0x41 8N1 -> empty falls within 10*CLKS_PER_BIT+4 cycles of the start edge; dout=0x41; frame_err=0.
REQ-036 Send 17 bytes 0x00..0x10, no reads -> full=1 after the 16th byte; overrun=1; after draining, reads return 0x00..0x0F in order.
REQ-037 Send 0x55 with stop bit low -> frame_err=1, empty stays 1; err_clr -> frame_err=0; a following 0x AA is received correctly.
REQ-038 2-cycle low pulse on idle rx -> no push and no flag; the FSM returns to IDLE.
REQ-039 rst asserted at bit 4 of 0xC3, then 0x3C sent -> only 0x3C is received.
REQ-040 With HOST_UART_PARITY_EN, send 0x07 with parity bit 0 -> frame_err=1 and no push; with parity bit 1 -> dout=0x07.
